// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
// The CSUM state exists only when BOOT_CSUM_EN is defined.
package boot_pkg;

    localparam int unsigned BOOT_LEN_BYTES = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
`ifdef BOOT_CSUM_EN
        StCsum,
`endif
        StDone,
        StErr
    } boot_state_e;

endpackage

// File: rtl/boot_timeout_cnt.sv
// Inter-byte timeout counter: synchronous clear, count enable, and a flag raised in the
// cycle whose increment would land on TIMEOUT_CYC-1.
module boot_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // A clear in the same cycle wins, so a late byte never times out.
    assign tc = en && !clr && (cnt_q == CNT_MAX - CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Parses LEN/payload[/CSUM] frames from the UART RX path and writes instruction memory.
// Define BOOT_CSUM_EN to expect and check a trailing XOR checksum byte.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned MAX_WORDS   = 1024,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              boot_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned IDX_W  = $clog2(BYTES_PER_WORD);
    localparam int unsigned LEN_W  = 8 * BOOT_LEN_BYTES;
    localparam int unsigned PART_W = 8 * (BYTES_PER_WORD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W:0]  WC_ONE   = (ADDR_W + 1)'(1);

    boot_state_e       state_q;
    logic [7:0]        len_lo_q;
    logic [ADDR_W:0]   len_q;
    logic [IDX_W-1:0]  byte_idx_q;
    logic [PART_W-1:0] word_q;
`ifdef BOOT_CSUM_EN
    logic [7:0]        csum_q;
`endif

    logic [LEN_W-1:0] len_raw;
    logic             len_bad;
    logic             last_word;
    logic             tmo_clr;
    logic             tmo_en;
    logic             tmo;

    assign len_raw   = {rx_data, len_lo_q};
    assign len_bad   = (len_raw == '0) || (32'(len_raw) > MAX_WORDS);
    assign last_word = (word_count + WC_ONE) == len_q;
    assign tmo_clr   = rx_done || ((state_q == StIdle) && boot_req);
`ifdef BOOT_CSUM_EN
    assign tmo_en    = (state_q == StLenHi) || (state_q == StData) || (state_q == StCsum);
`else
    assign tmo_en    = (state_q == StLenHi) || (state_q == StData);
`endif

    boot_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (tmo_clr),
        .en  (tmo_en),
        .tc  (tmo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            len_lo_q   <= '0;
            len_q      <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
`ifdef BOOT_CSUM_EN
            csum_q     <= '0;
`endif
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
        end else begin
            imem_we   <= 1'b0;
            load_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (boot_req) begin
                        load_err   <= 1'b0;
                        word_count <= '0;
                        byte_idx_q <= '0;
`ifdef BOOT_CSUM_EN
                        csum_q     <= '0;
`endif
                        cpu_rst    <= 1'b1;
                        state_q    <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (rx_done) begin
                        len_lo_q <= rx_data;
                        state_q  <= StLenHi;
                    end
                end
                StLenHi: begin
                    if (rx_done) begin
                        if (len_bad) begin
                            load_err <= 1'b1;
                            state_q  <= StErr;
                        end else begin
                            len_q   <= (ADDR_W + 1)'(len_raw);
                            state_q <= StData;
                        end
                    end else if (tmo) begin
                        load_err <= 1'b1;
                        state_q  <= StErr;
                    end
                end
                StData: begin
                    if (rx_done) begin
                        byte_idx_q <= byte_idx_q + IDX_W'(1);
                        word_q     <= {rx_data, word_q[PART_W-1:8]};
`ifdef BOOT_CSUM_EN
                        csum_q     <= csum_q ^ rx_data;
`endif
                        if (byte_idx_q == LAST_IDX) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_count[ADDR_W-1:0];
                            imem_wdata <= {rx_data, word_q};
                            word_count <= word_count + WC_ONE;
                            if (last_word) begin
`ifdef BOOT_CSUM_EN
                                state_q <= StCsum;
`else
                                state_q <= StDone;
`endif
                            end
                        end
                    end else if (tmo) begin
                        load_err <= 1'b1;
                        state_q  <= StErr;
                    end
                end
`ifdef BOOT_CSUM_EN
                StCsum: begin
                    if (rx_done) begin
                        if (rx_data == csum_q) begin
                            load_done <= 1'b1;
                            cpu_rst   <= 1'b0;
                            state_q   <= StDone;
                        end else begin
                            load_err <= 1'b1;
                            state_q  <= StErr;
                        end
                    end else if (tmo) begin
                        load_err <= 1'b1;
                        state_q  <= StErr;
                    end
                end
`endif
                StDone: begin
`ifndef BOOT_CSUM_EN
                    // Without a CSUM byte the pulse trails the final write by one cycle.
                    load_done <= 1'b1;
                    cpu_rst   <= 1'b0;
`endif
                    state_q <= StIdle;
                end
                StErr: begin
                    cpu_rst <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Boot-load controller that sequences the UART receive path to fill instruction memory before the RISC-V core runs. It consumes bytes delivered by the UART RX deserializer, parses a length/payload/checksum frame, assembles little-endian 32-bit words, and issues one instruction-memory write per word. It holds the core in reset until a frame completes without error.

## Interface
- `ADDR_W`, 10, instruction-memory word-address width.
- `MAX_WORDS`, 1024, largest accepted word count; must be ≤ 2^ADDR_W.
- `TIMEOUT_CYC`, 1000000, inter-byte timeout in `clk` cycles.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  received byte; valid while `rx_done`=1.
- `rx_done`  in  1  one-cycle pulse, new byte from the UART RX path.
- `boot_req`  in  1  start a load; honoured only in IDLE.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  assembled word.
- `cpu_rst`  out  1  core reset, active-high.
- `load_done`  out  1  one-cycle pulse, frame accepted.
- `load_err`  out  1  sticky error flag.
- `word_count`  out  ADDR_W+1  words written in the current load.

## Operation
- Frame: LEN_LO, LEN_HI (N, 16-bit little-endian), 4·N payload bytes (each word LSB first), then CSUM (XOR of all payload bytes).
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE: `boot_req` → clear `load_err`, `word_count`, and the running XOR; set `cpu_rst`=1; go to LEN_LO.
- LEN_LO/LEN_HI: each `rx_done` latches a length byte. After LEN_HI, N=0 or N>MAX_WORDS → ERR; otherwise → DATA.
- DATA: a 2-bit byte index shifts bytes into the word register, and each byte is XORed into the checksum. On the 4th byte, `imem_we` pulses on the next cycle with `imem_addr`=`word_count`. `word_count` increments in the same cycle. When `word_count` reaches N → CSUM.
- CSUM: on `rx_done`, if the byte equals the running XOR → DONE; otherwise → ERR.
- DONE: pulse `load_done`, clear `cpu_rst`, → IDLE.
- ERR: set `load_err`, keep `cpu_rst`=1, → IDLE.
- Timeout counter:
  - Cleared on every `rx_done` and on entering LEN_LO.
  - Counts in LEN_HI, DATA and CSUM only; LEN_LO waits indefinitely.
  - Reaching TIMEOUT_CYC−1 → ERR.
- `boot_req` outside IDLE is ignored. `rx_done` in IDLE, DONE or ERR is discarded.
- `rx_done` in the same cycle as a timeout expiry: the byte wins and the counter clears.

## Timing
- Reset values:
  - outputs: `cpu_rst`=1; `imem_we`, `imem_addr`, `imem_wdata`, `load_done`, `load_err`, `word_count` all 0;
  - internal: state IDLE, XOR 0, byte index 0.
- `imem_we` is registered: asserted exactly 1 cycle after the `rx_done` of the word's 4th byte. `addr` and `wdata` are stable in that cycle.
- `load_done` is high 1 cycle after the accepting CSUM `rx_done`. `cpu_rst` falls in the same cycle.
- ERR → IDLE takes 1 cycle. `load_err` rises in the ERR cycle and holds until the next accepted `boot_req`.
- Back-to-back `rx_done` on consecutive cycles must be handled without loss.
- `rst` asserted mid-load aborts immediately: every output returns to its reset value and partial words are discarded.

## Configuration
- `BOOT_CSUM_EN` defined: CSUM byte expected and checked, as above.
- `BOOT_CSUM_EN` undefined:
  - no XOR logic and no CSUM state;
  - reaching `word_count`=N goes directly to DONE;
  - `load_done` is then high 1 cycle after the final `imem_we`.

## Structure
- Package `boot_pkg`: state enum, `BOOT_LEN_BYTES`=2, `BYTES_PER_WORD`=4.
- Sub-module `boot_timeout_cnt`: clear, enable and terminal-count flag, parameterized by TIMEOUT_CYC.

## Test plan
- Valid frame: bytes 02 00 13 00 00 00 EF BE AD DE 31 → writes addr0=0x00000013 and addr1=0xDEADBEEF, then `load_done` pulse, `cpu_rst`=0, `word_count`=2.
- Same frame with CSUM 0x30 → both writes occur, then `load_err`=1, `cpu_rst` stays 1, no `load_done`.
- Length 00 00, then a separate run with MAX_WORDS+1 → ERR after LEN_HI, zero writes, `load_err`=1.
- Send 02 00 13 then idle → `load_err`=1 exactly TIMEOUT_CYC cycles after the last `rx_done`; a new `boot_req` clears `load_err`.
- Pull `rst` low after 5 payload bytes → all outputs at reset values. A following full valid frame writes from addr0.
- Build without `BOOT_CSUM_EN`, send the first frame minus its last byte → `load_done` 1 cycle after the addr1 write.
